// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and the reset NOP.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PC_SEL_W = 2;

    localparam logic [PC_SEL_W-1:0] PC_PLUS4 = 2'd0;
    localparam logic [PC_SEL_W-1:0] PC_JUMP  = 2'd1;
    localparam logic [PC_SEL_W-1:0] PC_JALR  = 2'd2;
    localparam logic [PC_SEL_W-1:0] PC_RESET = 2'd3;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_next_pc_mux.sv
// Combinational next-PC selection and link-value adder.
module next_pc_mux #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jump_target,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);
    import fetch_unit_pkg::*;

    assign pc_plus4 = pc + 32'd4;

    // JALR clears bit 0 of the computed target.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            PC_PLUS4: next_pc = pc_plus4;
            PC_JUMP:  next_pc = jump_target;
            PC_JALR:  next_pc = alu_result & ~32'd1;
            PC_RESET: next_pc = RESET_VECTOR;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and instruction register, fetches over a req/ack port.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = fetch_unit_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_EN,
    input  logic [1:0]  pc_SEL,
    input  logic        instr_EN,
    input  logic [31:0] jump_target,
    input  logic [31:0] alu_result,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        fetch_busy,
    output logic        misaligned,
    output logic        proto_err
);
    import fetch_unit_pkg::*;

    fetch_state_e state;
    logic [31:0]  next_pc;
    logic [31:0]  fetch_pc;

    next_pc_mux #(.RESET_VECTOR(RESET_VECTOR)) u_next_pc_mux (
        .pc          (pc),
        .pc_sel      (pc_SEL),
        .jump_target (jump_target),
        .alu_result  (alu_result),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4)
    );

    // A combined pc_EN + instr_EN fetches from the freshly loaded PC.
    assign fetch_pc   = pc_EN ? next_pc : pc;
    assign imem_req   = (state == F_WAIT);
    assign fetch_busy = imem_req;
    assign imem_addr  = pc;
    assign misaligned = |pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= F_IDLE;
            pc         <= RESET_VECTOR;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (pc_EN) begin
                        pc <= next_pc;
                        if (next_pc != pc) inst_valid <= 1'b0;
                    end
                    if (instr_EN) begin
                        inst_valid <= 1'b0;
                        if (fetch_pc[1:0] == 2'b00) state <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    // Commands during an outstanding fetch are dropped and flagged.
                    if (pc_EN || instr_EN) proto_err <= 1'b1;
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= F_IDLE;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_EN;
    logic [1:0]  pc_SEL;
    logic        instr_EN;
    logic [31:0] jump_target;
    logic [31:0] alu_result;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        fetch_busy;
    logic        misaligned;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_valid;
    bit          m_busy;
    bit          m_err;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_EN       (pc_EN),
        .pc_SEL      (pc_SEL),
        .instr_EN    (instr_EN),
        .jump_target (jump_target),
        .alu_result  (alu_result),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .inst        (inst),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .inst_valid  (inst_valid),
        .fetch_busy  (fetch_busy),
        .misaligned  (misaligned),
        .proto_err   (proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_inst  = 32'h0000_0013;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the architectural rules, applied to the inputs held across the edge.
    task automatic model_step();
        logic [31:0] tgt;
        if (m_busy) begin
            if (pc_EN || instr_EN) m_err = 1'b1;
            if (imem_ack) begin
                m_inst  = imem_rdata;
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
        end else begin
            tgt = m_pc;
            if (pc_EN) begin
                case (pc_SEL)
                    2'd0:    tgt = m_pc + 32'd4;
                    2'd1:    tgt = jump_target;
                    2'd2:    tgt = alu_result - (alu_result % 2);
                    default: tgt = 32'h0000_0000;
                endcase
            end
            if (tgt != m_pc) m_valid = 1'b0;
            if (instr_EN) begin
                m_valid = 1'b0;
                if (tgt % 4 == 0) m_busy = 1'b1;
            end
            m_pc = tgt;
        end
    endtask

    // Compare all outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pc",         pc,                          m_pc);
            chk("imem_addr",  imem_addr,                   m_pc);
            chk("pc_plus4",   pc_plus4,                    m_pc + 32'd4);
            chk("imem_req",   32'(imem_req),               32'(m_busy));
            chk("fetch_busy", 32'(fetch_busy),             32'(m_busy));
            chk("inst",       inst,                        m_inst);
            chk("inst_valid", 32'(inst_valid),             32'(m_valid));
            chk("misaligned", 32'(misaligned),             32'(m_pc % 4 != 0));
            chk("proto_err",  32'(proto_err),              32'(m_err));
        end
    end

    task automatic idle_inputs();
        pc_EN       = 1'b0;
        pc_SEL      = 2'd0;
        instr_EN    = 1'b0;
        jump_target = 32'h0;
        alu_result  = 32'h0;
        imem_rdata  = 32'h0;
        imem_ack    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!reset) model_step();
    endtask

    // Async reset pulse placed mid-cycle, then released away from any edge.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int req_cycles;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Zero-wait fetch from address 0
        instr_EN = 1'b1;
        cyc();
        instr_EN = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0037;
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_req", 32'(imem_req), 32'd1);
        cyc();
        imem_ack = 1'b0;
        chk("t1_inst", inst, 32'h0000_0037);
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_req_drop", 32'(imem_req), 32'd0);

        // Fetch with three wait cycles
        instr_EN = 1'b1;
        cyc();
        instr_EN = 1'b0; imem_rdata = 32'h1234_5678;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req && fetch_busy) req_cycles++;
            if (i < 3) chk("t2_inst_hold", inst, 32'h0000_0037);
            imem_ack = (i == 3);
            cyc();
        end
        imem_ack = 1'b0;
        chk("t2_req_cycles", 32'(req_cycles), 32'd4);
        chk("t2_inst", inst, 32'h1234_5678);

        // Combined jump + fetch, then JALR
        pc_EN = 1'b1; pc_SEL = 2'd1; jump_target = 32'h0000_0100;
        cyc();
        chk("t3_pc100", pc, 32'h0000_0100);
        instr_EN = 1'b1; jump_target = 32'h0000_0200;
        cyc();
        pc_EN = 1'b0; instr_EN = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
        chk("t3_addr", imem_addr, 32'h0000_0200);
        chk("t3_req", 32'(imem_req), 32'd1);
        cyc();
        imem_ack = 1'b0;
        pc_EN = 1'b1; pc_SEL = 2'd2; alu_result = 32'h0000_0305;
        cyc();
        chk("t3_jalr", pc, 32'h0000_0304);

        // Wrap and misaligned target
        pc_SEL = 2'd1; jump_target = 32'hFFFF_FFFC;
        cyc();
        pc_SEL = 2'd0;
        cyc();
        chk("t4_wrap", pc, 32'h0);
        pc_SEL = 2'd1; jump_target = 32'h0000_0102;
        cyc();
        pc_EN = 1'b0;
        chk("t4_misaligned", 32'(misaligned), 32'd1);
        instr_EN = 1'b1;
        cyc();
        instr_EN = 1'b0;
        chk("t4_refused_req", 32'(imem_req), 32'd0);
        chk("t4_refused_valid", 32'(inst_valid), 32'd0);

        // pc_EN during WAIT is dropped and flagged
        pc_EN = 1'b1; pc_SEL = 2'd1; jump_target = 32'h0000_0040; instr_EN = 1'b1;
        cyc();
        instr_EN = 1'b0; jump_target = 32'h0000_0080;
        cyc();
        pc_EN = 1'b0;
        chk("t5_pc_hold", pc, 32'h0000_0040);
        chk("t5_err", 32'(proto_err), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        cyc();
        imem_ack = 1'b0;
        chk("t5_err_sticky", 32'(proto_err), 32'd1);
        chk("t5_done", 32'(imem_req), 32'd0);

        // Reset mid-WAIT, then a late ack
        instr_EN = 1'b1;
        cyc();
        instr_EN = 1'b0;
        mid_reset();
        chk("t6_pc", pc, 32'h0);
        chk("t6_err", 32'(proto_err), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        chk("t6_late_ack", inst, 32'h0000_0013);
        chk("t6_late_req", 32'(imem_req), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(499) == 0) begin
                idle_inputs();
                mid_reset();
                continue;
            end
            pc_SEL     = 2'($urandom_range(3));
            alu_result = $urandom;
            imem_rdata = $urandom;
            r = $urandom_range(15);
            if (r == 0)      jump_target = 32'hFFFF_FFFC;
            else if (r < 3)  jump_target = $urandom;
            else             jump_target = $urandom & 32'hFFFF_FFFC;
            if (m_busy) begin
                imem_ack = ($urandom_range(2) == 0);
                pc_EN    = ($urandom_range(39) == 0);
                instr_EN = ($urandom_range(39) == 0);
            end else begin
                imem_ack = ($urandom_range(3) == 0);
                pc_EN    = ($urandom_range(2) == 0);
                instr_EN = ($urandom_range(1) == 0);
            end
            cyc();
        end

        idle_inputs();
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
